matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
// PURPOSE
//   Upstream feeder for the element-by-element matrix register block.
//   Accepts a valid/ready stream of nBits words and turns it into row/column/value/write
//   commands covering all M*N elements exactly once, in row-major or column-major order.
//   Raises done when the full matrix has been issued, so the pseudo-inverse datapath
//   can start on the flattened matrix.
// PARAMETERS
//   M      4   matrix rows
//   N      4   matrix columns
//   nBits  32  width of data word and of row/column index outputs
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low
//   start      in   1      begin a load; sampled only in IDLE
//   transpose  in   1      captured with start: 0 = row-major, 1 = column-major
//   in_valid   in   1      input word valid
//   in_data    in   nBits  input word
//   in_ready   out  1      loader will accept in_data this cycle
//   row        out  nBits  target row index, zero-extended
//   coloumn    out  nBits  target column index, zero-extended
//   value      out  nBits  word to write
//   write      out  1      one-cycle write strobe for row/coloumn/value
//   busy       out  1      load in progress (LOAD or DONE state)
//   done       out  1      one-cycle pulse: matrix complete
//   count      out  nBits  elements accepted in the current load
// BEHAVIOUR
//   Reset (reset==0 at posedge)
//     - state=IDLE
//     - in_ready, write, busy, done = 0
//     - row, coloumn, value, count = 0
//     - takes priority over every other input, including mid-load
//     - a partial load is abandoned; no further write is issued
//   States
//     - IDLE: in_ready=0. start=1 -> LOAD; latch transpose, clear indices and count.
//     - LOAD: in_ready=1. An accept is in_valid & in_ready.
//       On each accept:
//         - next cycle: write=1; row/coloumn = current index pair; value=in_data
//         - count increments
//         - the index advances
//       Cycles without an accept: write=0; row/coloumn/value hold.
//       The accept of element M*N -> DONE.
//     - DONE (one cycle): in_ready=0.
//         - final write=1 is asserted in this cycle, and done=1 in the same cycle
//         - next state is IDLE
//   Index order
//     - row-major: coloumn counts 0..N-1, then wraps to 0 and row increments
//     - column-major: row counts 0..M-1, then wraps to 0 and coloumn increments
//     - both start at (0,0) and end at (M-1,N-1)
//     - the index pair never leaves range
//   Latency
//     - accept at cycle t -> write at cycle t+1
//     - throughput is 1 element per cycle with in_valid held high
//     - a full load takes M*N+1 cycles after the cycle where start is sampled
//   Boundary cases
//     - start while busy: ignored
//     - start in the DONE cycle: ignored (the load begins only once the FSM is in IDLE)
//     - in_valid in IDLE/DONE: not accepted; data is held by the producer
//     - transpose changes during a load: no effect until the next start
//     - count holds its final value M*N after done, until the next start clears it
//     - M=1 or N=1: the single index stays 0 and the other sweeps
//     - reset in the same cycle as an accept: the accept is discarded
// TESTING
//   - Reset: hold reset=0 for 3 cycles with start=1, in_valid=1 -> write=0, busy=0,
//     in_ready=0, count=0.
//   - Row-major, M=N=4: start, then stream 1..16 back-to-back
//     -> 16 consecutive writes (0,0)=1, (0,1)=2 ... (3,3)=16
//     -> done pulses once, together with the write of 16
//   - Column-major: transpose=1, stream 1..16
//     -> writes (0,0)=1, (1,0)=2, (2,0)=3, (3,0)=4, (0,1)=5 ... (3,3)=16
//   - Bubbles: in_valid alternates 1/0
//     -> 16 writes at alternate cycles; row/coloumn hold between writes; done after 32 cycles
//   - Abort: reset=0 after 7 accepts
//     -> no write the following cycle; IDLE; a new start restarts at (0,0) with count=0
//   - Ignored start: pulse start at element 5 and again in the DONE cycle
//     -> exactly one sequence of 16 writes and one done pulse

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Turns a valid/ready word stream into row/coloumn/value write commands covering an M x N matrix.
// Latency: an accepted word produces its write one cycle later; done shares the cycle of the final write.
// Backpressure: in_ready is high only while loading, so the producer holds its word in IDLE and DONE.
module matrix_stream_loader #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int nBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             transpose,
  input  logic             in_valid,
  input  logic [nBits-1:0] in_data,
  output logic             in_ready,
  output logic [nBits-1:0] row,
  output logic [nBits-1:0] coloumn,
  output logic [nBits-1:0] value,
  output logic             write,
  output logic             busy,
  output logic             done,
  output logic [nBits-1:0] count
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0]    RMAX  = RW'(M - 1);
  localparam logic [CW-1:0]    CMAX  = CW'(N - 1);
  localparam logic [nBits-1:0] TOTAL = nBits'(M * N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             tr_q, tr_d;
  logic [RW-1:0]    ridx_q, ridx_d;
  logic [CW-1:0]    cidx_q, cidx_d;
  logic [nBits-1:0] count_q, count_d;
  logic [nBits-1:0] row_q, row_d;
  logic [nBits-1:0] col_q, col_d;
  logic [nBits-1:0] value_q, value_d;
  logic             write_q, write_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             accept;

  assign accept = in_ready_q & in_valid;

  // Next-state, index advance and registered-output values for the load sequencer.
  always_comb begin
    state_d = state_q;
    tr_d    = tr_q;
    ridx_d  = ridx_q;
    cidx_d  = cidx_q;
    count_d = count_q;
    row_d   = row_q;
    col_d   = col_q;
    value_d = value_q;
    write_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          tr_d    = transpose;
          ridx_d  = '0;
          cidx_d  = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          write_d = 1'b1;
          row_d   = nBits'(ridx_q);
          col_d   = nBits'(cidx_q);
          value_d = in_data;
          count_d = count_q + nBits'(1);
          // Inner index sweeps fastest; both wrap so the pair stays in range after the last element.
          if (!tr_q) begin
            if (cidx_q == CMAX) begin
              cidx_d = '0;
              ridx_d = (ridx_q == RMAX) ? '0 : ridx_q + 1'b1;
            end else begin
              cidx_d = cidx_q + 1'b1;
            end
          end else begin
            if (ridx_q == RMAX) begin
              ridx_d = '0;
              cidx_d = (cidx_q == CMAX) ? '0 : cidx_q + 1'b1;
            end else begin
              ridx_d = ridx_q + 1'b1;
            end
          end
          if (count_q == TOTAL - nBits'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers; synchronous active-low reset abandons any partial load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tr_q       <= 1'b0;
      ridx_q     <= '0;
      cidx_q     <= '0;
      count_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      value_q    <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tr_q       <= tr_d;
      ridx_q     <= ridx_d;
      cidx_q     <= cidx_d;
      count_q    <= count_d;
      row_q      <= row_d;
      col_q      <= col_d;
      value_q    <= value_d;
      write_q    <= write_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign row      = row_q;
  assign coloumn  = col_q;
  assign value    = value_q;
  assign write    = write_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: directed loads with literal checks plus randomized traffic.
// A behavioural model (element number -> index pair) is compared against the DUT every cycle.
// Inputs change on the falling edge; the model samples them on the rising edge.
module tb_matrix_stream_loader;

  localparam int M   = 4;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TOT = M * N;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b1;
  logic         transpose = 1'b0;
  logic         in_valid = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic [W-1:0] row, coloumn, value, count;
  logic         write, busy, done;

  always #5 clk = ~clk;

  matrix_stream_loader #(.M(M), .N(N), .nBits(W)) dut (
    .clk(clk), .reset(reset), .start(start), .transpose(transpose),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .row(row), .coloumn(coloumn), .value(value), .write(write),
    .busy(busy), .done(done), .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: phase 0 idle, 1 loading, 2 matrix complete; m_k = elements taken.
  int           m_phase = 0;
  int           m_k     = 0;
  bit           m_tr    = 0;
  logic [W-1:0] e_row = '0, e_col = '0, e_val = '0;
  logic         e_wr = 0, e_done = 0;

  typedef struct {
    int           c;
    logic [W-1:0] r, cl, v;
    logic         w, d;
  } ent_t;
  ent_t log_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      m_phase = 0; m_k = 0; m_tr = 0;
      e_row = '0; e_col = '0; e_val = '0; e_wr = 0; e_done = 0;
    end else begin
      e_wr = 0; e_done = 0;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_k = 0; m_tr = transpose; end
        1: if (in_valid) begin
             e_wr = 1;
             if (m_tr) begin e_row = W'(m_k % M); e_col = W'(m_k / M); end
             else      begin e_row = W'(m_k / N); e_col = W'(m_k % N); end
             e_val = in_data;
             m_k++;
             if (m_k == TOT) begin m_phase = 2; e_done = 1; end
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: model samples inputs at the rising edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("write", write, e_wr);
    chk("done", done, e_done);
    chk("busy", busy, m_phase != 0);
    chk("in_ready", in_ready, m_phase == 1);
    chk("count", count, m_k);
    chk("row", row, e_row);
    chk("coloumn", coloumn, e_col);
    chk("value", value, e_val);
    if (write || done) log_q.push_back('{c: cyc, r: row, cl: coloumn, v: value, w: write, d: done});
  endtask

  task automatic run_load(input bit tr, input bit gap, input int restart_at, input int abort_after);
    int s_cyc, next, n, nw, nd, dc;
    bit pend;
    log_q.delete();
    start = 1; transpose = tr; in_valid = 0; s_cyc = cyc;
    tick();
    start = 0; transpose = ~tr;
    next = 1; n = 0;
    while (next <= TOT && n < 400) begin
      if (abort_after > 0 && next == abort_after + 1) break;
      in_valid = gap ? (n % 2 == 0) : 1'b1;
      in_data  = W'(next);
      start    = (next == restart_at);
      pend     = in_valid && in_ready;
      tick();
      n++;
      if (pend) next++;
    end
    in_valid = 0; start = 0;
    if (n >= 400) chk("load_timeout", next, TOT + 1);
    if (abort_after > 0) begin
      reset = 0; in_valid = 1; in_data = 'h99;
      tick();
      chk("abort_write", write, 0);
      chk("abort_busy", busy, 0);
      chk("abort_count", count, 0);
      reset = 1; in_valid = 0;
      tick();
      return;
    end
    if (restart_at > 0) start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    nw = 0; nd = 0; dc = 0;
    foreach (log_q[i]) begin
      if (log_q[i].w) nw++;
      if (log_q[i].d) begin nd++; dc = log_q[i].c - s_cyc; end
    end
    chk("n_writes", nw, TOT);
    chk("n_done", nd, 1);
    chk("done_latency", dc, gap ? 32 : 17);
    chk("count_hold", count, 16);
    if (log_q.size() >= 16) begin
      chk("first_rc", {log_q[0].r, log_q[0].cl}, {32'd0, 32'd0});
      chk("first_v", log_q[0].v, 1);
      chk("second_rc", {log_q[1].r, log_q[1].cl}, tr ? {32'd1, 32'd0} : {32'd0, 32'd1});
      chk("fifth_rc", {log_q[4].r, log_q[4].cl}, tr ? {32'd0, 32'd1} : {32'd1, 32'd0});
      chk("fifth_v", log_q[4].v, 5);
      chk("last_rc", {log_q[15].r, log_q[15].cl}, {32'd3, 32'd3});
      chk("last_v", log_q[15].v, 16);
      chk("last_done", log_q[15].d, 1);
    end else begin
      chk("log_size", log_q.size(), 16);
    end
  endtask

  initial begin
    // Reset held three cycles with start and in_valid asserted.
    repeat (3) tick();
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    reset = 1; start = 0; in_valid = 0;
    tick();

    run_load(0, 0, 0, 0);   // row-major, back-to-back
    run_load(1, 0, 0, 0);   // column-major
    run_load(0, 1, 0, 0);   // bubbles
    run_load(1, 0, 0, 7);   // abort after seven accepts
    run_load(0, 0, 0, 0);   // restart from (0,0)
    run_load(0, 0, 5, 0);   // start pulses mid-load and in DONE

    // Randomized traffic, including occasional resets mid-load.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      start     = ($urandom_range(0, 7) == 0);
      transpose = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      tick();
    end
    reset = 1; start = 0; in_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
